decode_regfile: RTL and testbench

DECODE_REGFILE -- requirements
Module: decode_regfile

---
 rtl/decode_regfile_pkg.sv | 12 +
 rtl/rf_read_port.sv | 28 ++
 rtl/decode_regfile.sv | 103 ++++++++++
 tb/tb_decode_regfile.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_regfile_pkg.sv
// Shared encodings and default sizes for the decode-stage register file.
package decode_regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;
endpackage

// File: rtl/rf_read_port.sv
// One read port: zero forcing for r0, bypass from the pending write, then array.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]             busy,
  input  logic [AW-1:0]                   addr,
  input  logic                            en,
  input  logic                            pend_v,
  input  logic [AW-1:0]                   pend_a,
  input  logic [DATA_W-1:0]               pend_d,
  output logic [DATA_W-1:0]               data,
  output logic                            stall
);
  always_comb begin
    data = '0;
    if (addr == '0)
      data = '0;
    else if (pend_v && pend_a == addr)
      data = pend_d;
    else
      data = regs[addr];
  end

  assign stall = en & busy[addr];
endmodule

// File: rtl/decode_regfile.sv
// Decode-stage register file: two-stage write-back commit, load scoreboard,
// bypassed combinational read ports and immediate extension.
module decode_regfile
  import decode_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = NUM_REGS - 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_stall,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic                     wr_valid,
  input  logic [AW-1:0]            wr_addr,
  input  logic [1:0]               wr_src,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic [DATA_W-1:0]        link_pc,
  input  logic                     ld_issue,
  input  logic [AW-1:0]            ld_addr,
  input  logic [15:0]              imm_in,
  input  logic                     imm_zero,
  output logic [DATA_W-1:0]        imm_out,
  output logic [NUM_REGS-1:0]      busy_vec
);
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy, busy_nxt;
  logic                            pend_v;
  logic [AW-1:0]                   pend_a;
  logic [DATA_W-1:0]               pend_d;

  wb_src_e           src;
  logic [AW-1:0]     eff_a;
  logic [DATA_W-1:0] wb_data;
  logic              wb_take, mem_clr;
  logic [NUM_RD-1:0] port_stall;

  assign src     = wb_src_e'(wr_src);
  assign eff_a   = (src == WB_LINK) ? LINK_A : wr_addr;
  assign wb_take = wr_valid && (src != WB_NONE) && (eff_a != '0);
  assign mem_clr = wr_valid && (src == WB_MEM);

  always_comb begin
    wb_data = alu_result;
    case (src)
      WB_MEM:  wb_data = mem_data;
      WB_LINK: wb_data = link_pc;
      default: wb_data = alu_result;
    endcase
  end

  // A load issue and a mem write-back on the same register: the issue wins.
  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++)
      busy_nxt[i] = (ld_issue && ld_addr == AW'(i)) ||
                    (busy[i] && !(mem_clr && eff_a == AW'(i)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs   <= '0;
      busy   <= '0;
      pend_v <= 1'b0;
      pend_a <= '0;
      pend_d <= '0;
    end else begin
      if (pend_v && pend_a != '0)
        regs[pend_a] <= pend_d;
      pend_v <= wb_take;
      if (wb_take) begin
        pend_a <= eff_a;
        pend_d <= wb_data;
      end
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW)) u_port (
      .regs   (regs),
      .busy   (busy),
      .addr   (rd_addr[k*AW +: AW]),
      .en     (rd_en[k]),
      .pend_v (pend_v),
      .pend_a (pend_a),
      .pend_d (pend_d),
      .data   (rd_data[k*DATA_W +: DATA_W]),
      .stall  (port_stall[k])
    );
  end

  assign rd_stall = |port_stall;
  assign busy_vec = busy;
  assign imm_out  = {{(DATA_W-16){~imm_zero & imm_in[15]}}, imm_in};
endmodule

// File: tb/tb_decode_regfile.sv
// Randomized and directed checks of decode_regfile against an architectural model.
module tb_decode_regfile;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NP*AW-1:0]  rd_addr = '0;
  logic [NP*DW-1:0]  rd_data;
  logic              rd_stall;
  logic [NP-1:0]     rd_en = '0;
  logic              wr_valid = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [1:0]        wr_src = 2'd0;
  logic [DW-1:0]     alu_result = '0, mem_data = '0, link_pc = '0;
  logic              ld_issue = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [15:0]       imm_in = '0;
  logic              imm_zero = 1'b0;
  logic [DW-1:0]     imm_out;
  logic [NR-1:0]     busy_vec;

  int total = 0;
  int bad   = 0;

  // Architectural view: the value a read must see right after an accepted write.
  logic [DW-1:0] mdl [NR];
  logic [NR-1:0] mbusy;

  always #5 clock = ~clock;

  decode_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_stall(rd_stall), .rd_en(rd_en), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_src(wr_src), .alu_result(alu_result), .mem_data(mem_data), .link_pc(link_pc),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .imm_in(imm_in), .imm_zero(imm_zero),
    .imm_out(imm_out), .busy_vec(busy_vec)
  );

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    mbusy = '0;
  endtask

  task automatic cyc();
    int ea;
    @(posedge clock);
    if (!reset) begin
      ea = (wr_src == 2'd2) ? NR - 1 : int'(wr_addr);
      if (wr_valid && wr_src != 2'd3 && ea != 0)
        mdl[ea] = (wr_src == 2'd0) ? alu_result : (wr_src == 2'd1) ? mem_data : link_pc;
      if (wr_valid && wr_src == 2'd1) mbusy[ea] = 1'b0;
      if (ld_issue && ld_addr != 0) mbusy[ld_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input int a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_src = s; wr_addr = AW'(a);
    alu_result = d; mem_data = d; link_pc = d;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    return (a == 0) ? '0 : mdl[a];
  endfunction

  task automatic test_reset();
    model_clear();
    rd_en = '1;
    set_rd(5, 31);
    total++; if (rd_data !== '0) begin $display("FAIL reset_rd_data got=%h want=0", rd_data); bad++; end
    total++; if (busy_vec !== '0) begin $display("FAIL reset_busy got=%h want=0", busy_vec); bad++; end
    total++; if (rd_stall !== 1'b0) begin $display("FAIL reset_stall got=%b want=0", rd_stall); bad++; end
    reset = 1'b0;
    rd_en = '0;
  endtask

  task automatic test_reset_midstream();
    wr(2'd0, 5, 32'h1234); cyc();
    wr_valid = 1'b0; cyc();
    set_rd(5, 0);
    total++; if (rd_data[DW-1:0] !== 32'h1234) begin $display("FAIL mid_pre r5 got=%h want=00001234", rd_data[DW-1:0]); bad++; end
    wr(2'd0, 6, 32'hAAAA); ld_issue = 1'b1; ld_addr = 5'd8; cyc();
    wr_valid = 1'b0; ld_issue = 1'b0;
    #2 reset = 1'b1;
    model_clear();
    rd_en = '1;
    set_rd(5, 6);
    total++; if (rd_data !== '0) begin $display("FAIL mid_rd_data got=%h want=0", rd_data); bad++; end
    total++; if (busy_vec !== '0) begin $display("FAIL mid_busy got=%h want=0", busy_vec); bad++; end
    set_rd(8, 8);
    total++; if (rd_stall !== 1'b0) begin $display("FAIL mid_stall got=%b want=0", rd_stall); bad++; end
    cyc();
    reset = 1'b0;
    rd_en = '0;
    set_rd(5, 6);
    total++; if (rd_data !== '0) begin $display("FAIL post_reset r5/r6 got=%h want=0", rd_data); bad++; end
    wr(2'd0, 5, 32'h77); cyc();
    wr_valid = 1'b0;
    #1;
    total++; if (rd_data[DW-1:0] !== 32'h77) begin $display("FAIL first_write r5 got=%h want=00000077", rd_data[DW-1:0]); bad++; end
  endtask

  task automatic test_bypass();
    set_rd(3, 5);
    wr(2'd0, 3, 32'hDEADBEEF); cyc();
    wr_valid = 1'b0; #1;
    total++; if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin $display("FAIL bypass_pend got=%h want=deadbeef", rd_data[DW-1:0]); bad++; end
    total++; if (rd_data[DW +: DW] !== exp_rd(5)) begin $display("FAIL bypass_other got=%h want=%h", rd_data[DW +: DW], exp_rd(5)); bad++; end
    cyc();
    total++; if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin $display("FAIL bypass_array got=%h want=deadbeef", rd_data[DW-1:0]); bad++; end
    // Same-cycle request must not be visible before its edge.
    wr(2'd0, 3, 32'h0BADF00D); #1;
    total++; if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin $display("FAIL no_sameclk_bypass got=%h want=deadbeef", rd_data[DW-1:0]); bad++; end
    cyc(); wr_valid = 1'b0; #1;
    total++; if (rd_data[DW-1:0] !== exp_rd(3)) begin $display("FAIL bypass_second got=%h want=%h", rd_data[DW-1:0], exp_rd(3)); bad++; end
  endtask

  task automatic test_r0_link();
    wr(2'd0, 7, 32'h7777); cyc();
    wr(2'd0, 0, 32'hFFFFFFFF); cyc();
    wr_valid = 1'b0;
    set_rd(0, 7);
    total++; if (rd_data[DW-1:0] !== '0) begin $display("FAIL r0_read got=%h want=0", rd_data[DW-1:0]); bad++; end
    total++; if (rd_data[DW +: DW] !== 32'h7777) begin $display("FAIL r0_keeps_r7 got=%h want=00007777", rd_data[DW +: DW]); bad++; end
    wr(2'd2, 7, 32'h00400008); cyc();
    wr_valid = 1'b0; cyc();
    set_rd(31, 7);
    total++; if (rd_data[DW-1:0] !== 32'h00400008) begin $display("FAIL link_r31 got=%h want=00400008", rd_data[DW-1:0]); bad++; end
    total++; if (rd_data[DW +: DW] !== 32'h7777) begin $display("FAIL link_r7 got=%h want=00007777", rd_data[DW +: DW]); bad++; end
  endtask

  task automatic test_scoreboard();
    ld_issue = 1'b1; ld_addr = 5'd9; cyc();
    ld_issue = 1'b0;
    rd_en = 2'b01; set_rd(9, 0);
    total++; if (rd_stall !== 1'b1) begin $display("FAIL ld_stall got=%b want=1", rd_stall); bad++; end
    rd_en = 2'b10; #1;
    total++; if (rd_stall !== 1'b0) begin $display("FAIL ld_stall_unqual got=%b want=0", rd_stall); bad++; end
    rd_en = 2'b01;
    wr(2'd3, 9, 32'h99); cyc();
    total++; if (busy_vec !== mbusy || rd_stall !== 1'b1) begin $display("FAIL wb_none got=%h/%b want=%h/1", busy_vec, rd_stall, mbusy); bad++; end
    wr(2'd1, 9, 32'h55); cyc();
    wr_valid = 1'b0; #1;
    total++; if (rd_stall !== 1'b0) begin $display("FAIL mem_clear_stall got=%b want=0", rd_stall); bad++; end
    total++; if (rd_data[DW-1:0] !== 32'h55) begin $display("FAIL mem_data r9 got=%h want=00000055", rd_data[DW-1:0]); bad++; end
    ld_issue = 1'b1; ld_addr = 5'd9; wr(2'd1, 9, 32'h66); cyc();
    ld_issue = 1'b0; wr_valid = 1'b0; #1;
    total++; if (busy_vec[9] !== 1'b1 || rd_stall !== 1'b1) begin $display("FAIL set_wins got=%b/%b want=1/1", busy_vec[9], rd_stall); bad++; end
    wr(2'd1, 9, 32'h67); cyc();
    wr_valid = 1'b0; rd_en = '0; #1;
    total++; if (busy_vec !== mbusy) begin $display("FAIL busy_final got=%h want=%h", busy_vec, mbusy); bad++; end
  endtask

  task automatic test_back_to_back();
    set_rd(4, 0);
    for (int v = 1; v <= 3; v++) begin
      wr(2'd0, 4, DW'(v)); cyc();
      total++; if (rd_data[DW-1:0] !== DW'(v)) begin $display("FAIL b2b_%0d got=%h want=%h", v, rd_data[DW-1:0], DW'(v)); bad++; end
    end
    wr_valid = 1'b0; cyc();
    total++; if (rd_data[DW-1:0] !== 32'd3) begin $display("FAIL b2b_final got=%h want=00000003", rd_data[DW-1:0]); bad++; end
  endtask

  task automatic test_imm();
    logic [DW-1:0] e;
    imm_in = 16'h8001; imm_zero = 1'b0; #1;
    total++; if (imm_out !== 32'hFFFF8001) begin $display("FAIL imm_sext got=%h want=ffff8001", imm_out); bad++; end
    imm_zero = 1'b1; #1;
    total++; if (imm_out !== 32'h00008001) begin $display("FAIL imm_zext got=%h want=00008001", imm_out); bad++; end
    for (int i = 0; i < 20; i++) begin
      imm_in = 16'($urandom); imm_zero = 1'($urandom);
      e = (!imm_zero && imm_in >= 16'h8000) ? (32'hFFFF0000 + imm_in) : {16'h0, imm_in};
      #1;
      total++; if (imm_out !== e) begin $display("FAIL imm_rand in=%h z=%b got=%h want=%h", imm_in, imm_zero, imm_out, e); bad++; end
    end
  endtask

  task automatic test_random();
    int a0, a1;
    logic sx;
    for (int n = 0; n < 400; n++) begin
      wr(2'($urandom), int'($urandom_range(0, NR-1)), $urandom);
      wr_valid = ($urandom_range(0, 3) != 0);
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_addr  = AW'($urandom);
      a0 = $urandom_range(0, NR-1); a1 = $urandom_range(0, NR-1);
      rd_addr = {AW'(a1), AW'(a0)};
      rd_en = 2'($urandom);
      cyc();
      sx = (rd_en[0] && mbusy[a0]) || (rd_en[1] && mbusy[a1]);
      total++;
      if (rd_data[DW-1:0] !== exp_rd(a0) || rd_data[DW +: DW] !== exp_rd(a1) ||
          busy_vec !== mbusy || rd_stall !== sx) begin
        $display("FAIL rand_%0d rd=%h,%h busy=%h stall=%b want=%h,%h busy=%h stall=%b",
                 n, rd_data[DW-1:0], rd_data[DW +: DW], busy_vec, rd_stall,
                 exp_rd(a0), exp_rd(a1), mbusy, sx);
        bad++;
      end
    end
    wr_valid = 1'b0; ld_issue = 1'b0; rd_en = '0;
  endtask

  initial begin
    #12;
    test_reset();
    test_reset_midstream();
    test_bypass();
    test_r0_link();
    test_scoreboard();
    test_back_to_back();
    test_imm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
